// File: rtl/ov5640_cfg_pkg.sv
// rtl/ov5640_cfg_pkg.sv - shared constants, state codes and LUT entry helpers for the OV5640 config sequencer
package ov5640_cfg_pkg;

    typedef logic [3:0] seq_state_t;
    localparam seq_state_t S_IDLE   = 4'd0;
    localparam seq_state_t S_PWRUP  = 4'd1;
    localparam seq_state_t S_FETCH  = 4'd2;
    localparam seq_state_t S_DECODE = 4'd3;
    localparam seq_state_t S_XFER   = 4'd4;
    localparam seq_state_t S_DELAY  = 4'd5;
    localparam seq_state_t S_NEXT   = 4'd6;
    localparam seq_state_t S_DONE   = 4'd7;
    localparam seq_state_t S_ERR    = 4'd8;

    typedef logic [2:0] eng_state_t;
    localparam eng_state_t E_IDLE  = 3'd0;
    localparam eng_state_t E_START = 3'd1;
    localparam eng_state_t E_BIT   = 3'd2;
    localparam eng_state_t E_STOP  = 3'd3;
    localparam eng_state_t E_GAP   = 3'd4;

    localparam logic [31:0] END_MARK   = 32'hFFFF_FFFF;
    localparam logic [7:0]  DEV_SKIP0  = 8'h00;
    localparam logic [7:0]  DEV_SKIP1  = 8'hFF;
    localparam logic [15:0] SW_RST_REG = 16'h3008;
    localparam logic [9:0]  LUT_LAST   = 10'd1023;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_NACK  = 2'b01;
    localparam logic [1:0] ERR_NOEND = 2'b10;

    typedef struct packed {
        logic [7:0]  dev;
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } lut_entry_t;

    function automatic logic is_skip_dev(input logic [7:0] dev);
        return (dev == DEV_SKIP0) || (dev == DEV_SKIP1);
    endfunction

    // Writing 1 to bit 7 of the system-control register resets the sensor.
    function automatic logic is_soft_rst(input lut_entry_t e);
        return (e.reg_addr == SW_RST_REG) && e.data[7];
    endfunction

endpackage

// File: rtl/ov5640_cfg_seq_i2c_wr4_engine.sv
// rtl/ov5640_cfg_seq_i2c_wr4_engine.sv - bit-level I2C master that writes one 4-byte frame per go pulse
module i2c_wr4_engine
    import ov5640_cfg_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] bytes,
    input  logic        sda_i,
    output logic        scl_o,
    output logic        sda_oe,
    output logic        ack_ok,
    output logic        nack,
    output logic        idle
);

    localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);

    eng_state_t  state;
    logic [1:0]  q;
    logic [3:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] shreg;
    logic        got_nack;
    logic [15:0] tick_cnt;
    logic        tick;

    assign tick = (tick_cnt == 16'(QTR - 1));
    assign idle = (state == E_IDLE);

    // Every stage is one SCL period split into four quarters q0..q3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= E_IDLE;
            q        <= 2'd0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
            got_nack <= 1'b0;
            tick_cnt <= 16'd0;
            scl_o    <= 1'b1;
            sda_oe   <= 1'b0;
            ack_ok   <= 1'b0;
            nack     <= 1'b0;
        end else begin
            ack_ok   <= 1'b0;
            nack     <= 1'b0;
            tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
            case (state)
                E_IDLE: begin
                    if (go) begin
                        shreg    <= bytes;
                        state    <= E_START;
                        q        <= 2'd0;
                        bit_cnt  <= 4'd0;
                        byte_cnt <= 2'd0;
                        got_nack <= 1'b0;
                        tick_cnt <= 16'd0;
                    end
                end
                E_START, E_BIT, E_STOP, E_GAP: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (state)
                            E_START: begin
                                if (q == 2'd0) sda_oe <= 1'b1;
                                if (q == 2'd2) scl_o <= 1'b0;
                                if (q == 2'd3) state <= E_BIT;
                            end
                            E_BIT: begin
                                case (q)
                                    2'd0: sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~shreg[31];
                                    2'd1: scl_o <= 1'b1;
                                    2'd2: if (bit_cnt == 4'd8) got_nack <= sda_i;
                                    default: begin
                                        scl_o <= 1'b0;
                                        if (bit_cnt == 4'd8) begin
                                            bit_cnt <= 4'd0;
                                            if (got_nack || byte_cnt == 2'd3) state <= E_STOP;
                                            else byte_cnt <= byte_cnt + 2'd1;
                                        end else begin
                                            bit_cnt <= bit_cnt + 4'd1;
                                            shreg   <= {shreg[30:0], 1'b0};
                                        end
                                    end
                                endcase
                            end
                            E_STOP: begin
                                if (q == 2'd0) sda_oe <= 1'b1;
                                if (q == 2'd1) scl_o <= 1'b1;
                                if (q == 2'd2) sda_oe <= 1'b0;
                                if (q == 2'd3) state <= E_GAP;
                            end
                            default: begin
                                // Bus stays idle a full SCL period before the result is reported.
                                if (q == 2'd3) begin
                                    state <= E_IDLE;
                                    if (got_nack) nack <= 1'b1;
                                    else ack_ok <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ov5640_cfg_seq.sv
// rtl/ov5640_cfg_seq.sv - OV5640 register-table sequencer; define OV5640_CFG_RETRY_EN for NACK retries
module ov5640_cfg_seq
    import ov5640_cfg_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int I2C_FREQ      = 100_000,
    parameter int PWRUP_CYC     = 1_000_000,
    parameter int RST_DELAY_CYC = 250_000,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        scl_o,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

`ifdef OV5640_CFG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int RETRY_LIM = RETRY_EN ? MAX_RETRY : 0;

    seq_state_t  state;
    logic [31:0] entry_q;
    logic [31:0] cnt;
    logic [7:0]  retry_cnt;
    logic        launch;
    logic        eng_go;
    logic        eng_ack;
    logic        eng_nack;
    logic        eng_idle;

    assign eng_go = launch & eng_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lut_index <= 10'd0;
            entry_q   <= 32'd0;
            cnt       <= 32'd0;
            retry_cnt <= 8'd0;
            launch    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_code  <= ERR_OK;
        end else begin
            if (eng_go) launch <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_PWRUP;
                        lut_index <= 10'd0;
                        cnt       <= 32'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_code  <= ERR_OK;
                    end
                end
                S_PWRUP: begin
                    if (cnt >= 32'(PWRUP_CYC - 1)) begin
                        cnt   <= 32'd0;
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_FETCH: begin
                    entry_q <= lut_data;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    if (entry_q == END_MARK) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (is_skip_dev(entry_q[31:24])) begin
                        state <= S_NEXT;
                    end else begin
                        state     <= S_XFER;
                        launch    <= 1'b1;
                        retry_cnt <= 8'd0;
                    end
                end
                S_XFER: begin
                    if (eng_ack) begin
                        if (is_soft_rst(entry_q)) begin
                            cnt   <= 32'd0;
                            state <= S_DELAY;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (eng_nack) begin
                        // Re-sending relies on the engine's idle period after STOP.
                        if (retry_cnt != 8'(RETRY_LIM)) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            launch    <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            busy     <= 1'b0;
                            err_code <= ERR_NACK;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt >= 32'(RST_DELAY_CYC - 1)) begin
                        cnt   <= 32'd0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (lut_index == LUT_LAST) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_NOEND;
                    end else begin
                        lut_index <= lut_index + 10'd1;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    i2c_wr4_engine #(
        .CLK_FREQ(CLK_FREQ),
        .I2C_FREQ(I2C_FREQ)
    ) u_i2c (
        .clk   (clk),
        .rst   (rst),
        .go    (eng_go),
        .bytes (entry_q),
        .sda_i (sda_i),
        .scl_o (scl_o),
        .sda_oe(sda_oe),
        .ack_ok(eng_ack),
        .nack  (eng_nack),
        .idle  (eng_idle)
    );

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// tb/tb_ov5640_cfg_seq.sv - self-checking bench for ov5640_cfg_seq (honours OV5640_CFG_RETRY_EN)
module tb_ov5640_cfg_seq;

    localparam int CLK_FREQ      = 800;
    localparam int I2C_FREQ      = 100;
    localparam int PWRUP_CYC     = 20;
    localparam int RST_DELAY_CYC = 1000;
    localparam int MAX_RETRY     = 3;
    localparam int SCL_PERIOD    = 4 * (CLK_FREQ / (4 * I2C_FREQ));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  lut_index;
    logic [31:0] lut_data;
    logic        scl_o;
    logic        sda_oe;
    logic        sda_i;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic        slv_low = 1'b0;

    logic [31:0] lut [0:1023];
    assign lut_data = lut[lut_index];
    assign sda_i    = ~(sda_oe | slv_low);

    always #5 clk = ~clk;

    ov5640_cfg_seq #(
        .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .PWRUP_CYC(PWRUP_CYC),
        .RST_DELAY_CYC(RST_DELAY_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
        .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i), .busy(busy), .done(done), .err_code(err_code)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, want);
        end
    endtask

    // Expected frames from the LUT contents and the slave's NACK plan
    logic [31:0] exp_data[$];
    int          exp_n[$];
    logic        exp_done;
    logic [1:0]  exp_err;
    logic [9:0]  exp_idx;
    logic [23:0] nack_key = 24'h0;
    int          nack_total = 0;
    int          nack_left = 0;

    task automatic build_expect();
        logic [31:0] e;
        int fails, allowed;
        bit fin;
        exp_data.delete(); exp_n.delete();
        exp_done = 1'b0; exp_err = 2'd0; exp_idx = 10'd0; fin = 1'b0;
`ifdef OV5640_CFG_RETRY_EN
        allowed = MAX_RETRY + 1;
`else
        allowed = 1;
`endif
        for (int i = 0; i < 1024 && !fin; i++) begin
            e = lut[i];
            exp_idx = 10'(i);
            if (e == 32'hFFFF_FFFF) begin
                exp_done = 1'b1; fin = 1'b1;
            end else if (e[31:24] != 8'h00 && e[31:24] != 8'hFF) begin
                fails = (nack_total > 0 && e[31:8] == nack_key) ? nack_total : 0;
                for (int a = 0; a < fails && a < allowed; a++) begin
                    exp_data.push_back({8'h00, e[31:8]}); exp_n.push_back(3);
                end
                if (fails >= allowed) begin
                    exp_err = 2'd1; fin = 1'b1;
                end else begin
                    exp_data.push_back(e); exp_n.push_back(4);
                end
            end
            if (!fin && i == 1023) begin
                exp_done = 1'b1; exp_err = 2'd2;
            end
        end
    endtask

    // Bus slave and per-cycle compare
    logic        chk_en = 1'b0;
    logic        p_scl = 1'b1, p_sda = 1'b1, sd;
    logic        in_frame = 1'b0, ack_ph = 1'b0;
    int          bit_n = 0, byte_n = 0, cyc = 0, last_stop = -1;
    logic [7:0]  cur = 8'h0;
    logic [31:0] frm = 32'h0;
    logic [31:0] rcv[$];
    int          gaps[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            sd = ~(sda_oe | slv_low);
            if (rst) begin
                in_frame = 1'b0; slv_low = 1'b0; ack_ph = 1'b0;
                bit_n = 0; byte_n = 0; p_scl = 1'b1; p_sda = 1'b1;
            end else begin
                if (p_scl && scl_o && p_sda && !sd) begin
                    if (last_stop >= 0) gaps.push_back(cyc - last_stop);
                    in_frame = 1'b1; bit_n = 0; byte_n = 0; frm = 32'h0; ack_ph = 1'b0;
                end else if (in_frame && p_scl && scl_o && !p_sda && sd) begin
                    in_frame = 1'b0; last_stop = cyc; rcv.push_back(frm);
                    if (exp_n.size() == 0) begin
                        n_assert++; n_fail++;
                        $display("FAIL frame_unexpected: got %h, required no frame", frm);
                    end else begin
                        chk("frame_bytes", frm, exp_data.pop_front());
                        chk("frame_len", 32'(byte_n), 32'(exp_n.pop_front()));
                    end
                end else if (in_frame && !p_scl && scl_o) begin
                    if (!ack_ph) begin
                        cur = {cur[6:0], sd}; bit_n++;
                    end
                end else if (in_frame && p_scl && !scl_o) begin
                    if (ack_ph) begin
                        ack_ph = 1'b0; slv_low = 1'b0;
                    end else if (bit_n == 8) begin
                        frm = {frm[23:0], cur}; byte_n++; bit_n = 0; ack_ph = 1'b1;
                        slv_low = !(byte_n == 3 && nack_left > 0 && frm[23:0] == nack_key);
                        if (!slv_low) nack_left--;
                    end
                end
                if (chk_en && !busy) begin
                    chk("idle_scl", 32'(scl_o), 32'd1);
                    chk("idle_sda", 32'(sda_oe), 32'd0);
                end
                p_scl = scl_o;
                p_sda = ~(sda_oe | slv_low);
            end
        end
    end

    task automatic clear_lut();
        for (int i = 0; i < 1024; i++) lut[i] = 32'h0;
    endtask

    task automatic kick();
        nack_left = nack_total;
        build_expect();
        gaps.delete(); rcv.delete(); last_stop = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_seq(input int bound, input int poke);
        int k;
        kick();
        k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
            start = (k == poke);
        end
        start = 1'b0;
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("done", 32'(done), 32'(exp_done));
        chk("err_code", 32'(err_code), 32'(exp_err));
        chk("lut_index", 32'(lut_index), 32'(exp_idx));
        chk("frames_left", 32'(exp_n.size()), 32'd0);
    endtask

    initial begin
        int k;
        clear_lut();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lut_index", 32'(lut_index), 32'd0);
        chk("rst_scl", 32'(scl_o), 32'd1);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1: two writes then end marker
        lut[0] = 32'h7831_0311; lut[1] = 32'h7830_17FF; lut[2] = 32'hFFFF_FFFF;
        run_seq(20000, 0);
        chk("t1_nframes", 32'(rcv.size()), 32'd2);
        chk("t1_frame0", rcv[0], 32'h7831_0311);
        chk("t1_frame1", rcv[1], 32'h7830_17FF);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_idx", 32'(lut_index), 32'd2);

        // 2: skipped device codes, plus a start pulse while busy
        clear_lut();
        lut[0] = 32'h7831_0311; lut[1] = 32'h0030_3521; lut[2] = 32'hFF50_3D80;
        lut[3] = 32'h7830_17FF; lut[4] = 32'hFFFF_FFFF;
        run_seq(20000, 100);
        chk("t2_nframes", 32'(rcv.size()), 32'd2);
        chk("t2_idx", 32'(lut_index), 32'd4);

        // 3: soft-reset write stretches the following gap
        clear_lut();
        lut[0] = 32'h7830_0882; lut[1] = 32'h7831_0311; lut[2] = 32'h7830_0842;
        lut[3] = 32'h7830_17FF; lut[4] = 32'hFFFF_FFFF;
        run_seq(20000, 0);
        chk("t3_ngaps", 32'(gaps.size()), 32'd3);
        chk("t3_gap_softrst", 32'(gaps[0] >= RST_DELAY_CYC), 32'd1);
        chk("t3_gap_normal", 32'(gaps[2] < RST_DELAY_CYC), 32'd1);
        chk("t3_gap_min", 32'(gaps[2] >= SCL_PERIOD), 32'd1);

        // 4: NACK on reg_lo of entry 5
        clear_lut();
        for (int i = 0; i < 5; i++) lut[i] = 32'h7831_0000 | 32'(i);
        lut[5] = 32'h7830_3521; lut[6] = 32'h7830_3622; lut[7] = 32'hFFFF_FFFF;
        nack_key = 24'h783035;
        nack_total = 1;
        run_seq(20000, 0);
        chk("t4a_partial", rcv[5], 32'h0078_3035);
`ifdef OV5640_CFG_RETRY_EN
        chk("t4a_err", 32'(err_code), 32'd0);
        chk("t4a_nframes", 32'(rcv.size()), 32'd8);
`else
        chk("t4a_err", 32'(err_code), 32'd1);
        chk("t4a_idx", 32'(lut_index), 32'd5);
        chk("t4a_nframes", 32'(rcv.size()), 32'd6);
`endif
        nack_total = 4;
        run_seq(20000, 0);
        chk("t4b_err", 32'(err_code), 32'd1);
        chk("t4b_idx", 32'(lut_index), 32'd5);
`ifdef OV5640_CFG_RETRY_EN
        chk("t4b_nframes", 32'(rcv.size()), 32'd9);
`else
        chk("t4b_nframes", 32'(rcv.size()), 32'd6);
`endif
        nack_total = 2;
        run_seq(20000, 0);
`ifdef OV5640_CFG_RETRY_EN
        chk("t4c_done", 32'(done), 32'd1);
        chk("t4c_nframes", 32'(rcv.size()), 32'd9);
`else
        chk("t4c_err", 32'(err_code), 32'd1);
`endif
        nack_total = 0;

        // 5: no end marker, index stops at 1023
        clear_lut();
        lut[0] = 32'h7831_0311;
        run_seq(20000, 0);
        chk("t5_idx", 32'(lut_index), 32'd1023);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_err", 32'(err_code), 32'd2);
        chk("t5_nframes", 32'(rcv.size()), 32'd1);

        // 6: reset in the middle of a data byte, then re-run
        clear_lut();
        lut[0] = 32'h7831_0311; lut[1] = 32'h7830_17FF; lut[2] = 32'hFFFF_FFFF;
        kick();
        k = 0;
        while (!(in_frame && byte_n == 3 && bit_n >= 3) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_data", 32'(k < 5000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_scl", 32'(scl_o), 32'd1);
        chk("t6_sda_oe", 32'(sda_oe), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_data.delete(); exp_n.delete();
        @(negedge clk);
        run_seq(20000, 0);
        chk("t6_nframes", 32'(rcv.size()), 32'd2);
        chk("t6_frame0", rcv[0], 32'h7831_0311);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
